// File: rtl/pwm_capture.sv
// pwm_capture
// Measures an external PWM waveform in i_clk cycles. The module reports the
// high time and the rise-to-rise period of each complete cycle, with a
// one-cycle valid strobe. If no edge arrives for 2^WIDTH-1 clocks, the module
// raises a timeout flag instead of publishing stale numbers.
//
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous, active-high reset
//   i_pwm     PWM input, asynchronous to i_clk
//   o_high    high time of the last complete cycle (clocks)
//   o_period  rise-to-rise period of the last complete cycle (clocks)
//   o_valid   one-cycle strobe; o_high/o_period were updated this cycle
//   o_timeout level; no edge seen for 2^WIDTH-1 clocks, cleared by o_valid
//   o_level   synchronized input level latched when the timeout fired
//
// Parameters:
//   WIDTH        counter and output width; the counter saturates at 2^WIDTH-1
//   SYNC_STAGES  synchronizer depth, must be at least 2
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pwm,
  output logic [WIDTH-1:0] o_high,
  output logic [WIDTH-1:0] o_period,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_level
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s_d_reg;
  logic                   s;
  logic                   rise;
  logic                   fall;
  logic [WIDTH-1:0]       cnt_reg;
  logic [WIDTH-1:0]       high_tmp_reg;
  state_t                 state_reg;

  // Both edges see the same synchronizer latency, so the latency cancels out
  // of every measured interval.
  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~s_d_reg;
  assign fall = ~s & s_d_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_reg <= '0;
      s_d_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_pwm};
      s_d_reg  <= s;
    end
  end

  // The counter loads 1 on a rise, so cnt reads k in the k-th cycle after the
  // rise is detected. That makes the captured values equal H and P exactly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_reg <= '0;
    end else if (rise) begin
      cnt_reg <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      high_tmp_reg <= '0;
      o_high       <= '0;
      o_period     <= '0;
      o_valid      <= 1'b0;
      o_timeout    <= 1'b0;
      o_level      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The partial cycle before the first rise is discarded.
          // The counter keeps saturating here without raising a new timeout.
          if (rise) begin
            state_reg <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            high_tmp_reg <= cnt_reg;
            state_reg    <= LOW;
          end else if (!rise && cnt_reg == CNT_MAX) begin
            o_timeout <= 1'b1;
            o_level   <= s;
            state_reg <= IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            // This rise closes the current cycle and also opens the next one.
            o_high    <= high_tmp_reg;
            o_period  <= cnt_reg;
            o_valid   <= 1'b1;
            o_timeout <= 1'b0;
            state_reg <= HIGH;
          end else if (!fall && cnt_reg == CNT_MAX) begin
            o_timeout <= 1'b1;
            o_level   <= s;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture. It uses a WIDTH=16 instance for the
// steady-state, duty-change, extreme-duty and reset cases, and a WIDTH=8
// instance for the timeout cases. Each o_valid strobe is logged into queues
// at the falling clock edge.
module tb_pwm_capture;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic pwm16 = 1'b0;
  logic pwm8  = 1'b0;

  logic [15:0] h16, p16;
  logic        v16, to16, lv16;
  logic [7:0]  h8, p8;
  logic        v8, to8, lv8;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   vcyc8 = 0;
  int   tocyc8 = 0;
  logic to8_prev = 1'b0;

  logic [15:0] qh16[$];
  logic [15:0] qp16[$];
  logic        qt16[$];
  logic [7:0]  qh8[$];
  logic [7:0]  qp8[$];
  logic        qt8[$];

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_pwm(pwm16),
    .o_high(h16), .o_period(p16), .o_valid(v16),
    .o_timeout(to16), .o_level(lv16)
  );

  pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_pwm(pwm8),
    .o_high(h8), .o_period(p8), .o_valid(v8),
    .o_timeout(to8), .o_level(lv8)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (v16) begin
      qh16.push_back(h16);
      qp16.push_back(p16);
      qt16.push_back(to16);
    end
    if (v8) begin
      qh8.push_back(h8);
      qp8.push_back(p8);
      qt8.push_back(to8);
      vcyc8 = cyc;
    end
    if (to8 && !to8_prev) tocyc8 = cyc;
    to8_prev = to8;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One PWM period of h clocks high and p clocks total, starting on a falling edge.
  task automatic drive(input int sel, input int h, input int p);
    if (sel == 0) pwm16 = 1'b1; else pwm8 = 1'b1;
    repeat (h) @(negedge clk);
    if (sel == 0) pwm16 = 1'b0; else pwm8 = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  initial begin
    int eh;
    int ep;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_high16", h16, 0);
    chk("rst_period16", p16, 0);
    chk("rst_valid16", v16, 0);
    chk("rst_timeout16", to16, 0);
    chk("rst_level16", lv16, 0);
    chk("rst_high8", h8, 0);
    chk("rst_timeout8", to8, 0);
    rst = 1'b0;

    // Steady stream, then a duty change, then both duty extremes
    drive(0, 64, 256);
    #2;
    chk("first_period_no_valid", qh16.size(), 0);
    repeat (4) drive(0, 64, 256);
    repeat (2) drive(0, 200, 256);
    repeat (3) drive(0, 1, 2);
    repeat (2) drive(0, 255, 256);
    pwm16 = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("valid_count16", qh16.size(), 12);
    for (int i = 0; i < 12; i++) begin
      eh = (i < 5) ? 64 : (i < 7) ? 200 : (i < 10) ? 1 : 255;
      ep = (i < 7) ? 256 : (i < 10) ? 2 : 256;
      if (i < qh16.size()) begin
        chk($sformatf("high16[%0d]", i), qh16[i], eh);
        chk($sformatf("period16[%0d]", i), qp16[i], ep);
        chk($sformatf("timeout16[%0d]", i), qt16[i], 0);
      end
    end
    chk("hold_high16", h16, 255);
    chk("hold_period16", p16, 256);

    // Timeout with the input held high (WIDTH=8)
    drive(1, 10, 20);
    pwm8 = 1'b1;
    repeat (300) @(negedge clk);
    #2;
    chk("valid_count8_a", qh8.size(), 1);
    if (qh8.size() > 0) begin
      chk("high8[0]", qh8[0], 10);
      chk("period8[0]", qp8[0], 20);
      chk("timeout8[0]", qt8[0], 0);
    end
    chk("to_high_flag", to8, 1);
    chk("to_high_level", lv8, 1);
    chk("to_high_keep_h", h8, 10);
    chk("to_high_keep_p", p8, 20);
    chk("to_high_delay", tocyc8 - vcyc8, 255);

    // Resume: the first period is not a rise, so two more rises are needed
    repeat (2) drive(1, 5, 12);
    #2;
    chk("resume_no_valid", qh8.size(), 1);
    chk("resume_to_held", to8, 1);
    drive(1, 5, 12);
    drive(1, 5, 300);
    #2;
    chk("valid_count8_b", qh8.size(), 3);
    if (qh8.size() > 2) begin
      chk("high8[1]", qh8[1], 5);
      chk("period8[1]", qp8[1], 12);
      chk("timeout8[1]", qt8[1], 0);
      chk("high8[2]", qh8[2], 5);
      chk("period8[2]", qp8[2], 12);
    end

    // Timeout with the input held low
    chk("to_low_flag", to8, 1);
    chk("to_low_level", lv8, 0);
    chk("to_low_keep_h", h8, 5);
    chk("to_low_keep_p", p8, 12);
    chk("to_low_delay", tocyc8 - vcyc8, 255);

    // Reset pulse in the middle of a high phase on the WIDTH=16 instance
    qh16.delete();
    qp16.delete();
    qt16.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_high", h16, 0);
    chk("midrst_period", p16, 0);
    chk("midrst_valid", v16, 0);
    chk("midrst_timeout", to16, 0);
    chk("midrst_level", lv16, 0);
    @(negedge clk);
    rst = 1'b0;
    pwm16 = 1'b0;
    repeat (10) @(negedge clk);
    drive(0, 30, 100);
    #2;
    chk("postrst_no_valid", qh16.size(), 0);
    drive(0, 30, 100);
    pwm16 = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("postrst_count", qh16.size(), 2);
    if (qh16.size() > 1) begin
      chk("postrst_high0", qh16[0], 30);
      chk("postrst_period0", qp16[0], 100);
      chk("postrst_high1", qh16[1], 30);
      chk("postrst_period1", qp16[1], 100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
